// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780-style LCD write controller.
// The SETUP state exists only when LCD_SETUP_EN is defined.
package lcd_ctrl_pkg;

    localparam int DEF_CLK_DIVIDE   = 16;
    localparam int DEF_SETUP_CYCLES = 2;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

`ifdef LCD_SETUP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2
    } lcd_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd2
    } lcd_state_t;
`endif

endpackage

// File: rtl/lcd_edge_det.sv
// Registered rising-edge detector. The history register updates every
// cycle, so edges seen while the consumer is busy are simply lost.
module lcd_edge_det (
    input  logic clk,
    input  logic srst,
    input  logic din,
    output logic rise
);

    logic prev_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= din;
        end
    end

    assign rise = din & ~prev_reg;

endmodule

// File: rtl/lcd_ctrl.sv
// LCD write controller: latches a byte on an iStart rising edge and produces
// one CLK_DIVIDE-cycle enable pulse. Define LCD_SETUP_EN for a pre-pulse setup phase.
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int CLK_DIVIDE   = DEF_CLK_DIVIDE,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    localparam int MAX_CNT = (CLK_DIVIDE > SETUP_CYCLES) ? CLK_DIVIDE : SETUP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    lcd_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             en_reg, en_next;
    logic             done_reg, done_next;
    logic [7:0]       data_reg, data_next;
    logic             rs_reg, rs_next;
    logic             start_rise;

    lcd_edge_det u_edge (
        .clk  (iCLK),
        .srst (iRST),
        .din  (iStart),
        .rise (start_rise)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            en_reg    <= 1'b0;
            done_reg  <= 1'b0;
            data_reg  <= 8'h00;
            rs_reg    <= RS_CMD;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            en_reg    <= en_next;
            done_reg  <= done_next;
            data_reg  <= data_next;
            rs_reg    <= rs_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        en_next    = en_reg;
        done_next  = done_reg;
        data_next  = data_reg;
        rs_next    = rs_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start_rise) begin
                    data_next = iDATA;
                    rs_next   = (iRS == RS_DATA) ? RS_DATA : RS_CMD;
                    done_next = 1'b0;
                    cnt_next  = '0;
`ifdef LCD_SETUP_EN
                    state_next = (SETUP_CYCLES > 0) ? ST_SETUP : ST_PULSE;
`else
                    state_next = ST_PULSE;
`endif
                end
            end
`ifdef LCD_SETUP_EN
            ST_SETUP: begin
                // Leave on the SETUP_CYCLES-th edge so EN rises one edge later.
                if (cnt_reg == CNT_W'(SETUP_CYCLES - 1)) begin
                    cnt_next   = '0;
                    state_next = ST_PULSE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
`endif
            ST_PULSE: begin
                // cnt counts edges with EN already high; CLK_DIVIDE of them then done.
                if (cnt_reg == CNT_W'(CLK_DIVIDE)) begin
                    en_next    = 1'b0;
                    done_next  = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    en_next  = 1'b1;
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                en_next    = 1'b0;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign oDone    = done_reg;
    assign LCD_DATA = data_reg;
    assign LCD_RS   = rs_reg;
    assign LCD_EN   = en_reg;
    assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: directed scenarios then random traffic,
// compared every cycle against a timeline model of the transfer.
module tb_lcd_ctrl;

    localparam int N = 16;
`ifdef LCD_SETUP_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       rs = 1'b0;
    logic       start = 1'b0;
    logic       done_o, en_o, rw_o, rs_o;
    logic [7:0] lcd_data_o;

    lcd_ctrl #(.CLK_DIVIDE(N), .SETUP_CYCLES(2)) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iDATA    (data),
        .iRS      (rs),
        .iStart   (start),
        .oDone    (done_o),
        .LCD_DATA (lcd_data_o),
        .LCD_RW   (rw_o),
        .LCD_EN   (en_o),
        .LCD_RS   (rs_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: a transfer accepted at cycle t0 has EN high for t in [t0+S+1, t0+S+N]
    // and finishes (done=1, idle) at t0+S+N+1.
    bit         m_busy = 0;
    bit         m_done = 0;
    bit         m_prev = 0;
    bit         m_rs   = 0;
    logic [7:0] m_data = 8'h00;
    int         m_t0   = 0;

    int en_high_cnt = 0;
    int en_rise_cnt = 0;
    int done_rise_cyc = -1;
    bit last_en = 0;
    bit last_done = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        bit         r_i = rst;
        bit         s_i = start;
        logic [7:0] d_i = data;
        bit         rs_i = rs;
        bit         rise;
        bit         exp_en;
        int         k;
        @(posedge clk);
        #1;
        cyc++;
        if (r_i) begin
            m_busy = 0; m_done = 0; m_prev = 0; m_data = 8'h00; m_rs = 0;
        end else begin
            rise   = s_i && !m_prev;
            m_prev = s_i;
            if (m_busy) begin
                if (cyc - m_t0 == S + N + 1) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (rise) begin
                m_busy = 1;
                m_t0   = cyc;
                m_data = d_i;
                m_rs   = rs_i;
                m_done = 0;
                $display("[TB] transfer data=%h rs=%0b accepted at cycle %0d", d_i, rs_i, cyc);
            end
        end
        k = cyc - m_t0;
        exp_en = m_busy && (k >= S + 1) && (k <= S + N);
        chk("lcd_en",   {7'd0, en_o},   {7'd0, exp_en});
        chk("done",     {7'd0, done_o}, {7'd0, m_done});
        chk("lcd_data", lcd_data_o,     m_data);
        chk("lcd_rs",   {7'd0, rs_o},   {7'd0, m_rs});
        chk("lcd_rw",   {7'd0, rw_o},   8'h00);
        if (en_o) en_high_cnt++;
        if (en_o && !last_en) en_rise_cnt++;
        if (done_o && !last_done) done_rise_cyc = cyc;
        last_en   = en_o;
        last_done = done_o;
    endtask

    task automatic clear_counts();
        en_high_cnt   = 0;
        en_rise_cnt   = 0;
        done_rise_cyc = -1;
    endtask

    task automatic one_transfer(input logic [7:0] d, input logic r);
        int t0;
        clear_counts();
        data = d; rs = r; start = 1'b1;
        tick();
        t0 = cyc;
        start = 1'b0;
        data = ~d; rs = ~r;
        repeat (S + N + 4) tick();
        chk("en_width",  8'(en_high_cnt), 8'(N));
        chk("en_pulses", 8'(en_rise_cnt), 8'd1);
        chk("latency",   8'(done_rise_cyc - t0), 8'(S + N + 1));
    endtask

    initial begin
        // Reset and idle.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_data", lcd_data_o, 8'h00);
        chk("idle_done", {7'd0, done_o}, 8'h00);

        // Command then data byte.
        one_transfer(8'h0F, 1'b0);
        chk("cmd_data", lcd_data_o, 8'h0F);
        one_transfer(8'h41, 1'b1);
        chk("chr_rs", {7'd0, rs_o}, 8'h01);

        // Held start with a re-rise during the pulse: still one pulse.
        clear_counts();
        data = 8'hA5; rs = 1'b1; start = 1'b1;
        repeat (5) tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        repeat (94) tick();
        start = 1'b0;
        repeat (S + N + 4) tick();
        chk("held_pulses", 8'(en_rise_cnt), 8'd1);
        chk("held_width",  8'(en_high_cnt), 8'(N));

        // Abort mid-pulse with reset, then a normal transfer.
        data = 8'h33; rs = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("abort_en", {7'd0, en_o}, 8'h00);
        rst = 1'b0;
        repeat (2) tick();
        one_transfer(8'h5A, 1'b1);

        // Reset beats a simultaneous start; a held start then fires on release.
        clear_counts();
        data = 8'hC3; rs = 1'b1; start = 1'b1; rst = 1'b1;
        tick();
        chk("rst_prio_done", {7'd0, done_o}, 8'h00);
        rst = 1'b0;
        tick();
        start = 1'b0;
        repeat (S + N + 4) tick();
        chk("release_pulses", 8'(en_rise_cnt), 8'd1);
        chk("release_data", lcd_data_o, 8'hC3);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) start = ~start;
            data = 8'($urandom);
            rs   = 1'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
